// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths and FSM encoding for the fetch path.
// No ports; imported by the interface, the fetch FSM and its buffer.
package fetch_unit_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: program-memory read bus plus instruction-byte handshake.
// master = fetch unit (drives mem_req/mem_addr/instr_*), slave = memory+decoder.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output instr_valid,
    output instr_data,
    output instr_addr,
    input  instr_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  instr_valid,
    input  instr_data,
    input  instr_addr,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry prefetch buffer of {addr, byte}; flush beats push/pop.
// Ports: clock, reset_n, push/wdata, pop, flush, rdata (head), count.
module fetch_fifo #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] ent_q [2];
  logic [W-1:0] ent_d [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    do_pop   = pop && (cnt_q != 2'd0);
    // a full buffer only accepts a byte when the head leaves
    do_push  = push && ((cnt_q != 2'd2) || do_pop);
    if (flush) begin
      wr_d  = 1'b0;
      rd_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (do_push) begin
        ent_d[wr_q] = wdata;
        wr_d        = ~wr_q;
      end
      if (do_pop) begin
        rd_d = ~rd_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata = ent_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: one-outstanding-read instruction prefetcher with flush/drop.
// Ports: clock, reset_n, pc_addr in, pc_inc out, flush in, bus (master).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_inc,
  input  logic              flush,
  fetch_unit_if.master      bus
);

  localparam int EW = ADDR_W + DATA_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              push;
  logic              pop;
  logic              valid;
  logic [1:0]        count;
  logic [EW-1:0]     head;

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    pc_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && (int'(count) < DEPTH)) begin
          state_d    = REQ;
          mem_addr_d = pc_addr;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
          if (!flush) begin
            push   = 1'b1;
            pc_inc = 1'b1;
          end
        end else if (flush) begin
          // the read is still in flight; wait it out and throw it away
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign valid = (count != 2'd0);
  assign pop   = valid && bus.instr_ready;

  fetch_fifo #(
    .W (EW)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({mem_addr_q, bus.mem_rdata}),
    .pop     (pop),
    .flush   (flush),
    .rdata   (head),
    .count   (count)
  );

  assign bus.mem_req     = (state_q != IDLE);
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = valid;
  assign bus.instr_addr  = head[EW-1:DATA_W];
  assign bus.instr_data  = head[DATA_W-1:0];

endmodule
